axi_id_allocator: RTL and testbench
===================================

# axi_id_allocator

Dynamic ID allocation controller for an AXI ID-narrowing path. For each wide master ID it hands out a narrow slave ID, and it returns the same slave ID for as long as that master ID has transactions outstanding. It tracks outstanding counts per slave ID and restores the master ID when a completion arrives. One instance serves one direction: AW with B completions, or AR with R-last completions. It sits beside the address-channel forwarding logic and gates its valid/ready.

## Interface

Parameters:
- `MASTER_ID_WIDTH`, default 8: width of upstream (wide) IDs.
- `SLAVE_ID_WIDTH`, default 2: width of downstream IDs. The table has 2**SLAVE_ID_WIDTH slots.
- `ACTIVE_CNT_WIDTH`, default 4: per-slot outstanding counter width. Maximum outstanding per slot is 2**ACTIVE_CNT_WIDTH-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  an address transaction wants an ID.
- `req_id`  in  MASTER_ID_WIDTH  master ID of the request.
- `req_ready`  out  1  grant. The request is consumed on `req_valid && req_ready`.
- `req_slave_id`  out  SLAVE_ID_WIDTH  granted slave ID. Valid while `req_ready` is high.
- `rsp_valid`  in  1  completion fire: a B handshake, or an R handshake with last set.
- `rsp_slave_id`  in  SLAVE_ID_WIDTH  slave ID of the completion.
- `rsp_master_id`  out  MASTER_ID_WIDTH  restored master ID for `rsp_slave_id`.
- `free_cnt`  out  SLAVE_ID_WIDTH+1  number of unallocated slots.

## Operation

- **Slot state.** Each slot holds `{used, master_id, cnt}`. A slot is used exactly when cnt != 0.
- **Hit.** A hit occurs when a used slot has `master_id == req_id`. At most one slot can hit.
  - If the hit slot has cnt < max: `req_ready=1` and `req_slave_id` is the hit slot.
  - If the hit slot has cnt == max: `req_ready=0` (stall). The request must never be placed in another slot, because that would break same-ID ordering.
- **Miss.** If no slot hits:
  - If a free slot exists, allocate it according to the policy (see Configuration) and set `req_ready=1`.
  - If no slot is free, `req_ready=0`.
- **Ready gating.** `req_ready` is forced to 0 whenever `req_valid=0`.
- **Allocation fire.** The slot's master_id is set to `req_id` and its cnt is incremented.
- **Completion.** `rsp_valid` decrements the cnt of slot `rsp_slave_id`. When cnt reaches 0 the slot becomes free.
- **Same-cycle allocation and completion on one slot.** cnt is unchanged and master_id is rewritten with the same value.
- **Completion on a free slot (cnt==0).** This is a protocol error: the table is left unchanged and cnt must not wrap.
- **rsp_master_id.** Equals `{stored master_id[MASTER_ID_WIDTH-1:SLAVE_ID_WIDTH]... }` is not used here; `rsp_master_id` is the full stored master_id of slot `rsp_slave_id`, because slot index and master low bits are unrelated.
- **free_cnt.** The population count of free slots.

## Timing

- `req_ready`, `req_slave_id` and `rsp_master_id` are combinational from the inputs and the current table. There is no registered latency.
- Table updates take effect on the next rising edge. A slot freed in cycle N can be allocated from cycle N+1.
- A hit on a slot whose last completion fires in the same cycle is legal: cnt stays at 1.
- Reset values:
  - All slots have cnt=0 and master_id=0.
  - `req_ready=0`, `req_slave_id=0`, `rsp_master_id=0`, `free_cnt=2**SLAVE_ID_WIDTH`.
  - The round-robin pointer is 0.
- Reset mid-operation clears the whole table in one cycle. In-flight completions are discarded, and the surrounding fabric is reset at the same time.
- The combinational path req_id → req_ready must be broken upstream by a reverse register slice. This block never registers that path itself.

## Configuration

- Macro `AXI_ID_ALLOC_ROUND_ROBIN_EN`.
- **Defined.** The free-slot search starts at a pointer register and wraps modulo 2**SLAVE_ID_WIDTH. On each miss-allocation fire, the pointer advances to (allocated slot + 1). Hits do not move the pointer.
- **Undefined.** The lowest-index free slot is chosen, and no pointer register exists.
- Hit behaviour is identical in both builds.

## Structure

- The `axi_common` package gains `localparam`-free helper function `axi_id_popcount` (used for `free_cnt`).
- The slot struct stays local to the module because its widths are parameter-dependent.
- Sub-module `axi_id_alloc_find_free`: a parameterised rotating priority encoder with inputs free-mask and start index, and outputs found flag and index. With the macro undefined, start is tied to 0.

## Test plan

Settings for all scenarios: MASTER_ID_WIDTH=8, SLAVE_ID_WIDTH=2, ACTIVE_CNT_WIDTH=4.

- **Reset.** Assert rst for 2 cycles → free_cnt=4, rsp_master_id=0x00, req_ready=0. Then req 0x35 → req_ready=1, req_slave_id=0.
- **Reuse.** Three fires of 0x35 → all get slot 0, free_cnt=3. Then 0x12 → slot 1, free_cnt=2. Then rsp_slave_id=1 → rsp_master_id=0x12.
- **Exhaustion.** Fill slots 0–3 with 0x10, 0x11, 0x12, 0x13 (one each). Request 0x77 → req_ready=0. Complete slot 2 → 0x77 is granted slot 2 one cycle later (lowest-index build).
- **Saturation.** 15 fires of 0x35 → the 16th sees req_ready=0 while slot 0 has cnt=15. One completion on slot 0 → granted next cycle with cnt back at 15.
- **Simultaneous events.** Slot 1 has cnt=1 for 0x20. Fire a req for 0x20 and a completion on slot 1 in the same cycle → slot 1 cnt stays 1 and free_cnt is unchanged. A completion on free slot 3 → no state change.
- **Policy.** Allocate 0x40 then complete it, then request 0x41 → slot 1 with `AXI_ID_ALLOC_ROUND_ROBIN_EN` defined, slot 0 without it.

Source files
------------

// File: rtl/axi_common_pkg.sv
// Shared helpers for the AXI ID-narrowing path.
// axi_id_popcount counts set bits of a mask of up to 32 slots.
package axi_common;

  function automatic logic [31:0] axi_id_popcount(input logic [31:0] mask);
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + {31'b0, mask[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/axi_id_alloc_find_free.sv
// Rotating priority encoder: returns the first set bit of i_free_mask found
// when scanning upward from i_start and wrapping modulo 2**IDX_W.
module axi_id_alloc_find_free #(
  parameter int IDX_W = 2
) (
  input  logic [(1<<IDX_W)-1:0] i_free_mask,
  input  logic [IDX_W-1:0]      i_start,
  output logic                  o_found,
  output logic [IDX_W-1:0]      o_idx
);

  localparam int N_SLOTS = 1 << IDX_W;

  logic [IDX_W-1:0] w_cand;

  // Scanning from the far end down lets the smallest offset win last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      w_cand = i_start + IDX_W'(k);
      if (i_free_mask[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/axi_id_allocator.sv
// Hands out narrow slave IDs for wide master IDs, keeping one master ID on
// one slot while it has outstanding transactions. Optional macro
// AXI_ID_ALLOC_ROUND_ROBIN_EN selects a round-robin free-slot search.
module axi_id_allocator #(
  parameter int MASTER_ID_WIDTH  = 8,
  parameter int SLAVE_ID_WIDTH   = 2,
  parameter int ACTIVE_CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [MASTER_ID_WIDTH-1:0] req_id,
  output logic                       req_ready,
  output logic [SLAVE_ID_WIDTH-1:0]  req_slave_id,
  input  logic                       rsp_valid,
  input  logic [SLAVE_ID_WIDTH-1:0]  rsp_slave_id,
  output logic [MASTER_ID_WIDTH-1:0] rsp_master_id,
  output logic [SLAVE_ID_WIDTH:0]    free_cnt
);

  import axi_common::*;

  localparam int N_SLOTS = 1 << SLAVE_ID_WIDTH;
  localparam logic [ACTIVE_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [MASTER_ID_WIDTH-1:0]  master_id;
    logic [ACTIVE_CNT_WIDTH-1:0] cnt;
  } slot_t;

  slot_t r_slots [N_SLOTS];

  logic [N_SLOTS-1:0]        w_free_mask;
  logic                      w_hit;
  logic [SLAVE_ID_WIDTH-1:0] w_hit_idx;
  logic                      w_hit_full;
  logic                      w_found;
  logic [SLAVE_ID_WIDTH-1:0] w_free_idx;
  logic [SLAVE_ID_WIDTH-1:0] w_start;
  logic [SLAVE_ID_WIDTH-1:0] w_grant_idx;
  logic                      w_fire;
  logic [N_SLOTS-1:0]        w_inc;
  logic [N_SLOTS-1:0]        w_dec;

  // A used slot is one with a nonzero count; at most one can match req_id.
  always_comb begin
    w_free_mask = '0;
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_free_mask[i] = (r_slots[i].cnt == '0);
      if (!w_free_mask[i] && (r_slots[i].master_id == req_id)) begin
        w_hit     = 1'b1;
        w_hit_idx = SLAVE_ID_WIDTH'(i);
      end
    end
  end

  axi_id_alloc_find_free #(
    .IDX_W (SLAVE_ID_WIDTH)
  ) u_find_free (
    .i_free_mask (w_free_mask),
    .i_start     (w_start),
    .o_found     (w_found),
    .o_idx       (w_free_idx)
  );

  // A full hit slot stalls: spilling into another slot would reorder same-ID traffic.
  assign w_hit_full  = (r_slots[w_hit_idx].cnt == CNT_MAX);
  assign w_grant_idx = w_hit ? w_hit_idx : w_free_idx;
  assign req_ready   = req_valid && (w_hit ? !w_hit_full : w_found);
  assign req_slave_id = req_ready ? w_grant_idx : '0;
  assign w_fire      = req_ready;

  assign rsp_master_id = r_slots[rsp_slave_id].master_id;
  assign free_cnt      = (SLAVE_ID_WIDTH+1)'(axi_id_popcount(32'(w_free_mask)));

`ifdef AXI_ID_ALLOC_ROUND_ROBIN_EN
  logic [SLAVE_ID_WIDTH-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_fire && !w_hit) begin
      r_rr_ptr <= w_free_idx + SLAVE_ID_WIDTH'(1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  // Completions on a free slot are dropped so the counter never wraps.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_inc[i] = w_fire && (w_grant_idx == SLAVE_ID_WIDTH'(i));
      w_dec[i] = rsp_valid && (rsp_slave_id == SLAVE_ID_WIDTH'(i)) && !w_free_mask[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (w_inc[i]) begin
          r_slots[i].master_id <= req_id;
        end
        if (w_inc[i] && !w_dec[i]) begin
          r_slots[i].cnt <= r_slots[i].cnt + ACTIVE_CNT_WIDTH'(1);
        end else if (!w_inc[i] && w_dec[i]) begin
          r_slots[i].cnt <= r_slots[i].cnt - ACTIVE_CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_id_allocator.sv
// Bench for axi_id_allocator: directed scenarios then random traffic, all
// checked against a slot-table reference model; honours AXI_ID_ALLOC_ROUND_ROBIN_EN.
module tb_axi_id_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_id;
  logic       req_ready;
  logic [1:0] req_slave_id;
  logic       rsp_valid;
  logic [1:0] rsp_slave_id;
  logic [7:0] rsp_master_id;
  logic [2:0] free_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-slot owner and outstanding count, plus search pointer.
  int         m_cnt [4];
  logic [7:0] m_mid [4];
  int         m_ptr;

  logic       obs_rdy;
  logic [1:0] obs_slot;

  always #5 clk = ~clk;

  axi_id_allocator #(
    .MASTER_ID_WIDTH  (8),
    .SLAVE_ID_WIDTH   (2),
    .ACTIVE_CNT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_id        (req_id),
    .req_ready     (req_ready),
    .req_slave_id  (req_slave_id),
    .rsp_valid     (rsp_valid),
    .rsp_slave_id  (rsp_slave_id),
    .rsp_master_id (rsp_master_id),
    .free_cnt      (free_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 4; s++) begin
      m_cnt[s] = 0;
      m_mid[s] = 8'h00;
    end
    m_ptr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; req_id = 8'h00; rsp_valid = 1'b0; rsp_slave_id = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One cycle: drive at negedge, check combinational outputs, update model after posedge.
  task automatic step(input logic v, input logic [7:0] id, input logic rv,
                      input logic [1:0] rs, input string tag);
    int   hit, slot, start, s, nfree;
    logic rdy, miss, dec;
    @(negedge clk);
    req_valid = v; req_id = id; rsp_valid = rv; rsp_slave_id = rs;
    #1;
    hit = -1;
    for (int i = 0; i < 4; i++)
      if (m_cnt[i] > 0 && m_mid[i] == id) hit = i;
    rdy = 1'b0; slot = 0; miss = 1'b0;
    if (hit >= 0) begin
      rdy  = (m_cnt[hit] < 15);
      slot = hit;
    end else begin
`ifdef AXI_ID_ALLOC_ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < 4; k++) begin
        s = (start + k) % 4;
        if (!rdy && m_cnt[s] == 0) begin
          rdy = 1'b1; slot = s; miss = 1'b1;
        end
      end
    end
    if (!v) rdy = 1'b0;
    nfree = 0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] == 0) nfree++;
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, ".slave_id"}, 32'(req_slave_id), rdy ? 32'(slot) : 32'd0);
    chk({tag, ".free_cnt"}, 32'(free_cnt), 32'(nfree));
    chk({tag, ".rsp_master_id"}, 32'(rsp_master_id), 32'(m_mid[rs]));
    obs_rdy  = req_ready;
    obs_slot = req_slave_id;
    dec = rv && (m_cnt[rs] > 0);
    @(posedge clk);
    if (rdy) begin
      m_cnt[slot]++;
      m_mid[slot] = id;
      if (miss) m_ptr = (slot + 1) % 4;
    end
    if (dec) m_cnt[rs]--;
  endtask

  initial begin
    logic [7:0] ids [6];
    ids[0] = 8'h35; ids[1] = 8'h12; ids[2] = 8'h20;
    ids[3] = 8'h40; ids[4] = 8'h77; ids[5] = 8'h10;

    // Reset
    do_reset();
    #1;
    chk("reset.free_cnt", 32'(free_cnt), 32'd4);
    chk("reset.rsp_master_id", 32'(rsp_master_id), 32'h00);
    chk("reset.ready", 32'(req_ready), 32'd0);
    step(1, 8'h35, 0, 0, "reset.req");
    chk("reset.req_slot0", {31'd0, obs_rdy}, 32'd1);

    // Reuse
    do_reset();
    repeat (3) step(1, 8'h35, 0, 0, "reuse.35");
    chk("reuse.slot0", 32'(obs_slot), 32'd0);
    step(1, 8'h12, 0, 0, "reuse.12");
    chk("reuse.slot1", 32'(obs_slot), 32'd1);
    step(0, 8'h00, 1, 1, "reuse.rsp1");
    chk("reuse.restore", 32'(rsp_master_id), 32'h12);

    // Exhaustion
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0, 0, "exh.fill");
    step(1, 8'h77, 0, 0, "exh.stall");
    chk("exh.stall_ready", {31'd0, obs_rdy}, 32'd0);
    step(1, 8'h77, 1, 2, "exh.complete2");
    step(1, 8'h77, 0, 0, "exh.grant");
    chk("exh.grant_slot", 32'(obs_slot), 32'd2);

    // Saturation
    do_reset();
    repeat (15) step(1, 8'h35, 0, 0, "sat.fill");
    step(1, 8'h35, 0, 0, "sat.16th");
    chk("sat.16th_ready", {31'd0, obs_rdy}, 32'd0);
    step(1, 8'h35, 1, 0, "sat.complete");
    step(1, 8'h35, 0, 0, "sat.regrant");
    chk("sat.regrant_ready", {31'd0, obs_rdy}, 32'd1);
    step(1, 8'h35, 0, 0, "sat.full_again");
    chk("sat.full_again_ready", {31'd0, obs_rdy}, 32'd0);

    // Simultaneous events
    do_reset();
    step(1, 8'h10, 0, 0, "sim.a");
    step(1, 8'h20, 0, 0, "sim.b");
    step(1, 8'h20, 1, 1, "sim.both");
    chk("sim.both_slot", 32'(obs_slot), 32'd1);
    step(0, 8'h00, 1, 3, "sim.free_rsp");
    chk("sim.free_cnt", 32'(free_cnt), 32'd2);
    step(0, 8'h00, 0, 1, "sim.after");
    chk("sim.slot1_owner", 32'(rsp_master_id), 32'h20);

    // Policy
    do_reset();
    step(1, 8'h40, 0, 0, "pol.alloc");
    step(0, 8'h00, 1, 0, "pol.complete");
    step(1, 8'h41, 0, 0, "pol.next");
`ifdef AXI_ID_ALLOC_ROUND_ROBIN_EN
    chk("pol.slot", 32'(obs_slot), 32'd1);
`else
    chk("pol.slot", 32'(obs_slot), 32'd0);
`endif

    // Random traffic, including completions aimed at free slots
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), ids[$urandom_range(0, 5)],
           1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), "rand");
    end

    // Mid-operation reset clears everything
    do_reset();
    #1;
    chk("rst2.free_cnt", 32'(free_cnt), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
